// File: rtl/vga_window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_window_pkg
// Description : Shared constants and elaboration helpers for the VGA window
//               read-address generator.
//                 PIPE_LAT   - cycles from Xpixel/Ypixel to AddrRamOut
//                 oob_addr() - all-ones sentinel of a given width
//                 win_size() - window extent of an upscaled image dimension
// Revision    : 1.0  initial release
// ============================================================================
package vga_window_pkg;

    localparam int PIPE_LAT = 2;

    function automatic logic [63:0] oob_addr(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

    function automatic int win_size(input int dim, input int scale_log2);
        return dim << scale_log2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_window_addr_sync_delay.sv
`default_nettype none
// ============================================================================
// Module      : sync_delay
// Description : Fixed-depth shift register with synchronous reset to INIT.
//               A depth of zero degenerates to a plain wire.
//   clk     in   clock
//   rst     in   synchronous active-high reset, loads every stage with INIT
//   i_data  in   WIDTH-bit input
//   o_data  out  i_data delayed DEPTH cycles
// Revision    : 1.0  initial release
// ============================================================================
module sync_delay #(
    parameter int               WIDTH = 1,
    parameter int               DEPTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign o_data         = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] shift_d [DEPTH];
            logic [WIDTH-1:0] shift_q [DEPTH];

            always_comb begin
                shift_d[0] = i_data;
                for (int i = 1; i < DEPTH; i++) begin
                    shift_d[i] = shift_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rst) begin
                        shift_q[i] <= INIT;
                    end else begin
                        shift_q[i] <= shift_d[i];
                    end
                end
            end

            assign o_data = shift_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_window_addr.sv
`default_nettype none
// ============================================================================
// Module      : vga_window_addr
// Description : Two-stage pipeline mapping VGA pixel coordinates onto linear
//               frame-buffer read addresses for an IMG_W x IMG_H image placed
//               at (OFF_X, OFF_Y) and upscaled by 2^SCALE_LOG2. Outside the
//               window the address is all ones. Syncs are delayed to line up
//               with RAM read data.
//   Clock       in   pixel clock
//   Reset       in   synchronous active-high reset
//   Xpixel      in   current VGA column
//   Ypixel      in   current VGA line
//   Hsync_in    in   horizontal sync from VGA driver
//   Vsync_in    in   vertical sync from VGA driver
//   frame_done  in   one-cycle pulse, camera finished a frame
//   AddrRamOut  out  buffer read address (2 cycles after Xpixel/Ypixel)
//   InWindow    out  AddrRamOut is a valid image address
//   InWindow_d  out  InWindow delayed RAM_LAT cycles
//   Hsync_out   out  Hsync_in delayed 2+RAM_LAT cycles
//   Vsync_out   out  Vsync_in delayed 2+RAM_LAT cycles
//   WrBank      out  bank the camera writer must target
// Optional    : FRAME_SWAP_EN - double buffering; AddrRamOut MSB carries the
//               read bank, swapped on the Vsync activation after frame_done.
// Revision    : 1.0  initial release
// ============================================================================
module vga_window_addr
    import vga_window_pkg::*;
#(
    parameter int   IMG_W      = 176,
    parameter int   IMG_H      = 144,
    parameter int   X_W        = 10,
    parameter int   Y_W        = 9,
    parameter int   ADDR_W     = 15,
    parameter int   OFF_X      = 0,
    parameter int   OFF_Y      = 0,
    parameter int   SCALE_LOG2 = 0,
    parameter int   RAM_LAT    = 1,
    parameter logic SYNC_IDLE  = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [X_W-1:0]    Xpixel,
    input  logic [Y_W-1:0]    Ypixel,
    input  logic              Hsync_in,
    input  logic              Vsync_in,
    input  logic              frame_done,
    output logic [ADDR_W-1:0] AddrRamOut,
    output logic              InWindow,
    output logic              InWindow_d,
    output logic              Hsync_out,
    output logic              Vsync_out,
    output logic              WrBank
);

    localparam int WW = win_size(IMG_W, SCALE_LOG2);
    localparam int WH = win_size(IMG_H, SCALE_LOG2);
`ifdef FRAME_SWAP_EN
    localparam int LIN_W = ADDR_W - 1;
`else
    localparam int LIN_W = ADDR_W;
`endif
    localparam logic [ADDR_W-1:0] OOB     = ADDR_W'(oob_addr(ADDR_W));
    localparam longint            MAX_LIN = longint'(oob_addr(LIN_W));
    localparam int                SYNC_DEPTH = PIPE_LAT + RAM_LAT;

    // The sentinel must never alias a real pixel address.
    generate
        if (longint'(IMG_W) * longint'(IMG_H) > MAX_LIN) begin : g_chk_addr
            $error("vga_window_addr: image does not fit below the sentinel address");
        end
        if (WW > (1 << X_W) || WH > (1 << Y_W)) begin : g_chk_win
            $error("vga_window_addr: scaled window exceeds coordinate range");
        end
        if (SCALE_LOG2 > 2 || SCALE_LOG2 < 0) begin : g_chk_scale
            $error("vga_window_addr: SCALE_LOG2 must be 0, 1 or 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: window test and offset removal
    // ------------------------------------------------------------------
    logic           in_win_d, in_win_q;
    logic [X_W-1:0] rel_x_d, rel_x_q;
    logic [Y_W-1:0] rel_y_d, rel_y_q;
    logic [31:0]    x_ext, y_ext;

    // Compare in 32 bits so OFF+W cannot wrap; rel_* may wrap below the
    // offset but is discarded by in_win in that case.
    always_comb begin
        x_ext    = 32'(Xpixel);
        y_ext    = 32'(Ypixel);
        in_win_d = (x_ext >= 32'(OFF_X)) && (x_ext < 32'(OFF_X + WW)) &&
                   (y_ext >= 32'(OFF_Y)) && (y_ext < 32'(OFF_Y + WH));
        rel_x_d  = Xpixel - X_W'(OFF_X);
        rel_y_d  = Ypixel - Y_W'(OFF_Y);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            in_win_q <= 1'b0;
            rel_x_q  <= '0;
            rel_y_q  <= '0;
        end else begin
            in_win_q <= in_win_d;
            rel_x_q  <= rel_x_d;
            rel_y_q  <= rel_y_d;
        end
    end

    // ------------------------------------------------------------------
    // Read bank selection
    // ------------------------------------------------------------------
`ifdef FRAME_SWAP_EN
    logic vs_prev_d, vs_prev_q;
    logic pending_d, pending_q;
    logic rd_bank_d, rd_bank_q;
    logic vs_activate;

    // A coincident frame_done counts as pending on the same edge.
    always_comb begin
        vs_activate = (vs_prev_q == SYNC_IDLE) && (Vsync_in != SYNC_IDLE);
        vs_prev_d   = Vsync_in;
        pending_d   = pending_q | frame_done;
        rd_bank_d   = rd_bank_q;
        if (vs_activate) begin
            pending_d = 1'b0;
            if (pending_q || frame_done) begin
                rd_bank_d = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            vs_prev_q <= SYNC_IDLE;
            pending_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            vs_prev_q <= vs_prev_d;
            pending_q <= pending_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    assign WrBank = ~rd_bank_q;
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done;
    assign WrBank            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 2: downscale to image coordinates and linearise
    // ------------------------------------------------------------------
    logic [X_W-1:0]    col;
    logic [Y_W-1:0]    row;
    logic [LIN_W-1:0]  lin;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              win_d, win_q;

    always_comb begin
        col   = rel_x_q >> SCALE_LOG2;
        row   = rel_y_q >> SCALE_LOG2;
        lin   = LIN_W'(row) * LIN_W'(IMG_W) + LIN_W'(col);
        win_d = in_win_q;
`ifdef FRAME_SWAP_EN
        addr_d = in_win_q ? {rd_bank_q, lin} : OOB;
`else
        addr_d = in_win_q ? lin : OOB;
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            addr_q <= OOB;
            win_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            win_q  <= win_d;
        end
    end

    assign AddrRamOut = addr_q;
    assign InWindow   = win_q;

    // ------------------------------------------------------------------
    // Delay lines aligning syncs and InWindow with RAM read data
    // ------------------------------------------------------------------
    sync_delay #(
        .WIDTH (2),
        .DEPTH (SYNC_DEPTH),
        .INIT  ({SYNC_IDLE, SYNC_IDLE})
    ) u_sync_dly (
        .clk    (Clock),
        .rst    (Reset),
        .i_data ({Hsync_in, Vsync_in}),
        .o_data ({Hsync_out, Vsync_out})
    );

    sync_delay #(
        .WIDTH (1),
        .DEPTH (RAM_LAT),
        .INIT  (1'b0)
    ) u_win_dly (
        .clk    (Clock),
        .rst    (Reset),
        .i_data (win_q),
        .o_data (InWindow_d)
    );

endmodule
`default_nettype wire

// File: tb/tb_vga_window_addr.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_window_addr
// Description : Self-checking bench for vga_window_addr. Two instances share
//               the stimulus: A with default placement, B with 2x upscale at
//               (144,96). Expected outputs come from an arithmetic window
//               model and a per-cycle history ring.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_window_addr;

`ifdef FRAME_SWAP_EN
    localparam int AW   = 16;
    localparam bit SWAP = 1'b1;
`else
    localparam int AW   = 15;
    localparam bit SWAP = 1'b0;
`endif
    localparam int            LW  = SWAP ? AW - 1 : AW;
    localparam logic [AW-1:0] OOB = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [9:0]    xpix = '0;
    logic [8:0]    ypix = '0;
    logic          hs = 1'b1, vs = 1'b1, fd = 1'b0;

    logic [AW-1:0] addr_a, addr_b;
    logic          win_a, win_b, wind_a, wind_b;
    logic          hso_a, vso_a, hso_b, vso_b, wrb_a, wrb_b;

    always #20 clk = ~clk;

    vga_window_addr #(.ADDR_W(AW)) u_dut_a (
        .Clock(clk), .Reset(rst), .Xpixel(xpix), .Ypixel(ypix),
        .Hsync_in(hs), .Vsync_in(vs), .frame_done(fd),
        .AddrRamOut(addr_a), .InWindow(win_a), .InWindow_d(wind_a),
        .Hsync_out(hso_a), .Vsync_out(vso_a), .WrBank(wrb_a)
    );

    vga_window_addr #(.ADDR_W(AW), .SCALE_LOG2(1), .OFF_X(144), .OFF_Y(96)) u_dut_b (
        .Clock(clk), .Reset(rst), .Xpixel(xpix), .Ypixel(ypix),
        .Hsync_in(hs), .Vsync_in(vs), .frame_done(fd),
        .AddrRamOut(addr_b), .InWindow(win_b), .InWindow_d(wind_b),
        .Hsync_out(hso_b), .Vsync_out(vso_b), .WrBank(wrb_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n     = 0;
    int last_rst = 0;
    logic m_bank = 1'b0, m_pend = 1'b0, m_vs_prev = 1'b1;

    logic [AW-1:0] h_addr_a [8];
    logic [AW-1:0] h_addr_b [8];
    logic          h_win_a [8];
    logic          h_win_b [8];
    logic          h_hs [8];
    logic          h_vs [8];

    bit sweeping = 1'b0;
    int sweep_cnt = 0;
    int hits [32768];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    // Window placement from plain coordinate arithmetic.
    function automatic void model(input int x, input int y, input int offx, input int offy,
                                  input int s, input logic bank,
                                  output logic win, output logic [AW-1:0] addr);
        int ww, wh, lin;
        ww  = 176 * (1 << s);
        wh  = 144 * (1 << s);
        win = (x >= offx) && (x < offx + ww) && (y >= offy) && (y < offy + wh);
        lin = ((y - offy) / (1 << s)) * 176 + (x - offx) / (1 << s);
        if (!win)      addr = OOB;
        else if (SWAP) addr = AW'(lin + (bank ? (1 << LW) : 0));
        else           addr = AW'(lin);
    endfunction

    task automatic cycle(input logic r, input int x, input int y,
                         input logic h, input logic v, input logic f);
        int sa, ss;
        logic [AW-1:0] ea_a, ea_b;
        logic ew_a, ew_b, ewd_a, ewd_b, eh, ev;
        rst = r; xpix = 10'(x); ypix = 9'(y); hs = h; vs = v; fd = f;
        @(posedge clk);
        n++;
        if (r) begin
            last_rst  = n;
            m_bank    = 1'b0;
            m_pend    = 1'b0;
            m_vs_prev = 1'b1;
        end else begin
            if (SWAP) begin
                if (m_vs_prev && !v) begin
                    if (m_pend || f) m_bank = ~m_bank;
                    m_pend = 1'b0;
                end else begin
                    m_pend = m_pend | f;
                end
            end
            m_vs_prev = v;
        end
        model(x, y, 0, 0, 0, m_bank, h_win_a[n % 8], h_addr_a[n % 8]);
        model(x, y, 144, 96, 1, m_bank, h_win_b[n % 8], h_addr_b[n % 8]);
        h_hs[n % 8] = h;
        h_vs[n % 8] = v;
        #1;
        sa = n - 1;
        ss = n - 2;
        if (sa <= last_rst) begin
            ea_a = OOB; ew_a = 1'b0; ea_b = OOB; ew_b = 1'b0;
        end else begin
            ea_a = h_addr_a[sa % 8]; ew_a = h_win_a[sa % 8];
            ea_b = h_addr_b[sa % 8]; ew_b = h_win_b[sa % 8];
        end
        if (ss <= last_rst) begin
            ewd_a = 1'b0; ewd_b = 1'b0; eh = 1'b1; ev = 1'b1;
        end else begin
            ewd_a = h_win_a[ss % 8]; ewd_b = h_win_b[ss % 8];
            eh = h_hs[ss % 8]; ev = h_vs[ss % 8];
        end
        check_eq("addr_a", 32'(addr_a), 32'(ea_a));
        check_eq("win_a", 32'(win_a), 32'(ew_a));
        check_eq("wind_a", 32'(wind_a), 32'(ewd_a));
        check_eq("hsync_a", 32'(hso_a), 32'(eh));
        check_eq("vsync_a", 32'(vso_a), 32'(ev));
        check_eq("addr_b", 32'(addr_b), 32'(ea_b));
        check_eq("win_b", 32'(win_b), 32'(ew_b));
        check_eq("wind_b", 32'(wind_b), 32'(ewd_b));
        check_eq("hsync_b", 32'(hso_b), 32'(eh));
        check_eq("wrbank", 32'(wrb_a), SWAP ? 32'(~m_bank) : 32'd0);
        check_eq("wrbank_b", 32'(wrb_b), SWAP ? 32'(~m_bank) : 32'd0);
        if (sweeping && win_a) begin
            hits[int'(addr_a[LW-1:0])]++;
            sweep_cnt++;
        end
    endtask

    int t2x [5] = '{144, 147, 143, 495, 496};
    int t2y [5] = '{96, 98, 96, 383, 383};
    logic [AW-1:0] t2e [5];

    initial begin
        int dups, miss;
        logic rh, rv;
        t2e = '{AW'(0), AW'(177), OOB, AW'(25343), OOB};

        repeat (4) cycle(1, 0, 0, 1, 1, 0);

        // Default placement: corners and first column past the edge.
        cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 175, 143, 1, 1, 0);
        check_eq("tp1_origin", 32'(addr_a), 32'd0);
        cycle(0, 176, 0, 1, 1, 0);
        check_eq("tp1_corner", 32'(addr_a), 32'd25343);
        cycle(0, 700, 500, 1, 1, 0);
        check_eq("tp1_edge", 32'(addr_a), 32'(OOB));
        check_eq("tp1_edge_win", 32'(win_a), 32'd0);

        // 2x upscale with offset, including below-offset and past-edge.
        for (int i = 0; i < 6; i++) begin
            if (i < 5) cycle(0, t2x[i], t2y[i], 1, 1, 0);
            else       cycle(0, 700, 500, 1, 1, 0);
            if (i > 0) check_eq("tp2_addr", 32'(addr_b), 32'(t2e[i-1]));
        end

        // Reset in the middle of an in-window line.
        for (int x = 40; x < 70; x++) begin
            cycle(x == 55, x, 20, (x % 7) != 0, 1, 0);
            if (x == 55) check_eq("rst_addr", 32'(addr_a), 32'(OOB));
        end

`ifdef FRAME_SWAP_EN
        // Bank swap scenarios.
        cycle(0, 10, 10, 1, 1, 1);
        cycle(0, 10, 10, 1, 1, 0);
        cycle(0, 10, 10, 1, 0, 0);
        repeat (3) cycle(0, 10, 10, 1, 0, 0);
        check_eq("tp5_msb1", 32'(addr_a[AW-1]), 32'd1);
        check_eq("tp5_wr0", 32'(wrb_a), 32'd0);
        cycle(0, 10, 10, 1, 1, 0);
        cycle(0, 10, 10, 1, 1, 1);
        cycle(0, 10, 10, 1, 1, 1);
        cycle(0, 10, 10, 1, 0, 0);
        repeat (3) cycle(0, 10, 10, 1, 0, 0);
        check_eq("tp5_double", 32'(addr_a[AW-1]), 32'd0);
        cycle(0, 10, 10, 1, 1, 0);
        cycle(0, 10, 10, 1, 0, 0);
        repeat (3) cycle(0, 10, 10, 1, 0, 0);
        check_eq("tp5_nopend", 32'(addr_a[AW-1]), 32'd0);
        cycle(0, 10, 10, 1, 1, 0);
        cycle(0, 300, 300, 1, 0, 1);
        repeat (3) cycle(0, 300, 300, 1, 0, 0);
        check_eq("tp6_oob", 32'(addr_a), 32'(OOB));
        check_eq("tp6_wr", 32'(wrb_a), 32'd0);
`endif

        // Randomised coordinates, syncs, frame_done and occasional reset.
        rh = 1'b1;
        rv = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rh = ~rh;
            if ($urandom_range(0, 31) == 0) rv = ~rv;
            cycle($urandom_range(0, 199) == 0,
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                  rh, rv, $urandom_range(0, 31) == 0);
        end

        // Sweep covering the whole default window plus margin.
        cycle(0, 700, 500, 1, 1, 0);
        cycle(0, 700, 500, 1, 1, 0);
        for (int i = 0; i < 32768; i++) hits[i] = 0;
        sweeping = 1'b1;
        for (int y = 0; y < 146; y++) begin
            for (int x = 0; x < 180; x++) begin
                cycle(0, x, y, $urandom_range(0, 3) != 0, 1, 0);
            end
        end
        cycle(0, 700, 500, 1, 1, 0);
        cycle(0, 700, 500, 1, 1, 0);
        sweeping = 1'b0;
        dups = 0;
        miss = 0;
        for (int i = 0; i < 25344; i++) begin
            if (hits[i] == 0) miss++;
            if (hits[i] > 1)  dups++;
        end
        check_eq("sweep_count", 32'(sweep_cnt), 32'd25344);
        check_eq("sweep_missing", 32'(miss), 32'd0);
        check_eq("sweep_repeated", 32'(dups), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
